// File: rtl/pwm_dither_gen.sv
// Dithered PWM for the slow-DAC pin: 8-bit coarse compare plus a 16-bit per-period dither pattern.
// Optional feature macro: PWM_DITHER_EN (undefined: coarse compare only, dither bits not stored).
module pwm_dither_gen #(
  parameter int unsigned PERIOD = 156,
  parameter int unsigned SEQ    = 16,
  parameter int unsigned CW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cfg,
  output logic          pwm_o,
  output logic          cfg_ld,
  output logic          frame_o
);

  localparam int unsigned PW    = 16;
  localparam int unsigned HW    = CW - PW;
  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned IDX_W = $clog2(SEQ);
  localparam int unsigned CMP_W = CNT_W + 1;
`ifdef PWM_DITHER_EN
  localparam int unsigned CFG_RW = CW;
`else
  localparam int unsigned CFG_RW = HW;
`endif

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [CFG_RW-1:0] cfg_r;
  logic [CMP_W-1:0]  cmp;

  logic              cnt_wrap;
  logic              idx_wrap;
  logic              boundary;
  logic [CNT_W-1:0]  cnt_n;
  logic [IDX_W-1:0]  idx_n;
  logic [HW-1:0]     hi_src;
  logic [CMP_W-1:0]  sum;
  logic [CMP_W-1:0]  cmp_n;
`ifdef PWM_DITHER_EN
  logic [PW-1:0]     pat_src;
`else
  logic              unused_pat;
  assign unused_pat = ^cfg[PW-1:0];
`endif

  // Counter advance and saturated compare for the period about to start
  always_comb begin
    cnt_wrap = (cnt == CNT_W'(PERIOD - 1));
    idx_wrap = (idx == IDX_W'(SEQ - 1));
    boundary = cnt_wrap && idx_wrap;
    cnt_n    = cnt_wrap ? '0 : cnt + CNT_W'(1);
    idx_n    = idx;
    if (cnt_wrap) begin
      idx_n = idx_wrap ? '0 : idx + IDX_W'(1);
    end
    hi_src = boundary ? cfg[CW-1:PW] : cfg_r[CFG_RW-1 -: HW];
`ifdef PWM_DITHER_EN
    pat_src = boundary ? cfg[PW-1:0] : cfg_r[PW-1:0];
    sum     = CMP_W'(hi_src) + CMP_W'(pat_src[idx_n]);
`else
    sum     = CMP_W'(hi_src);
`endif
    cmp_n = (sum > CMP_W'(PERIOD)) ? CMP_W'(PERIOD) : sum;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= CNT_W'(PERIOD - 1);
      idx     <= IDX_W'(SEQ - 1);
      cfg_r   <= '0;
      cmp     <= '0;
      pwm_o   <= 1'b0;
      cfg_ld  <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      cfg_ld  <= boundary;
      frame_o <= boundary;
      if (boundary) begin
`ifdef PWM_DITHER_EN
        cfg_r <= cfg;
`else
        cfg_r <= cfg[CW-1:PW];
`endif
      end
      if (cnt_wrap) begin
        cmp <= cmp_n;
      end
      // Uses pre-edge cnt/cmp: one cycle latency, no glitch at the wrap when cmp==PERIOD
      pwm_o <= (CMP_W'(cnt) < cmp);
    end
  end

endmodule

// File: tb/tb_pwm_dither_gen.sv
// Scoreboard bench for pwm_dither_gen: per-period high counts queued at each frame load,
// popped as each observed period completes; cfg_ld/frame_o checked every cycle.
module tb_pwm_dither_gen;

  localparam int unsigned PERIOD = 156;
  localparam int unsigned SEQ    = 16;
  localparam int unsigned CW     = 24;
  localparam int          FRAME  = PERIOD * SEQ;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] cfg = 24'h9C0000;
  logic          pwm_o;
  logic          cfg_ld;
  logic          frame_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          k     = 0;
  int          acc   = 0;
  int          exp_q[$];
  bit          bnd;

  always #2 clk = ~clk;

  pwm_dither_gen #(.PERIOD(PERIOD), .SEQ(SEQ), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg),
    .pwm_o   (pwm_o),
    .cfg_ld  (cfg_ld),
    .frame_o (frame_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // High clocks expected in period q of a frame loaded with config c
  function automatic int exp_high(input logic [CW-1:0] c, input int q);
    int hi;
    bit dith;
    hi   = int'(c[23:16]);
    dith = c[q];
`ifndef PWM_DITHER_EN
    dith = 1'b0;
`endif
    hi = hi + int'(dith);
    return (hi > int'(PERIOD)) ? int'(PERIOD) : hi;
  endfunction

  // Monitor: inputs change at negedge+1, so rst/cfg here are what the DUT sampled at the last posedge
  always @(negedge clk) begin
    if (!rst) begin
      k   = 0;
      acc = 0;
      exp_q.delete();
      check("rst_pwm", 32'(pwm_o), 0);
      check("rst_cfg_ld", 32'(cfg_ld), 0);
      check("rst_frame", 32'(frame_o), 0);
    end else begin
      k++;
      bnd = ((k - 1) % FRAME) == 0;
      if (bnd) begin
        for (int q = 0; q < int'(SEQ); q++) exp_q.push_back(exp_high(cfg, q));
      end
      check("cfg_ld", 32'(cfg_ld), 32'(bnd));
      check("frame_o", 32'(frame_o), 32'(bnd));
      if (k >= 2) begin
        acc += int'(pwm_o);
        if (((k - 2) % int'(PERIOD)) == int'(PERIOD) - 1) begin
          if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
          else check("period_high", 32'(acc), 32'(exp_q.pop_front()));
          acc = 0;
        end
      end
    end
  end

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 40000) begin
        check("timeout", 32'(k), 32'(target));
        report();
      end
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    wait_k(10);
    cfg = 24'h000000;
    wait_k(3 * FRAME + 10);
    cfg = 24'hFF0000;
    wait_k(4 * FRAME + 10);
    cfg = 24'h4E0001;
    wait_k(5 * FRAME + 10);
    cfg = 24'h10FFFF;
    wait_k(6 * FRAME + 10);
    cfg = 24'h9BFFFF;
    wait_k(7 * FRAME + 10);
    cfg = 24'h200000;
    wait_k(8 * FRAME + 1 + 7 * int'(PERIOD) + 20);
    cfg = 24'h400000;
    wait_k(9 * FRAME + 10);
    cfg = 24'h640000;
    // Reset lands at cnt=80, idx=5 while the output is high
    wait_k(10 * FRAME + 861);
    check("pre_rst_pwm", 32'(pwm_o), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    wait_k(FRAME + 4);
    report();
  end

endmodule
